// File: rtl/brnch_pkg.sv
// Shared types and default parameters for the branch resolution unit.
//   brr_state_t : recovery FSM state (NORMAL / RECOVER)
//   ADDR_W_DEF  : default PC/address width
//   CNT_W_DEF   : default performance counter width
package brnch_pkg;

  typedef enum logic {NORMAL, RECOVER} brr_state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for branch performance monitoring.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears the count
//   inc : increment request for this cycle
//   cnt : current count, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/brnch_resolve_unit.sv
// Branch resolution and misprediction recovery.
// Carries the IF-stage prediction into ID in a shadow register, compares it
// with the outcome resolved in ID, and on a mismatch squashes IF/ID and
// redirects fetch. One RECOVER cycle follows each redirect so the squashed
// instruction now sitting in ID cannot resolve.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   stall_IF_ID             : hazard stall, IF/ID holds, nothing resolves
//   brch_instr_detectd_IF   : branch in IF
//   predict_br_taken        : predictor output for the IF branch
//   pc_plus4_IF             : PC+4 of the IF instruction
//   brch_instr_detectd_ID   : branch in ID, resolved this cycle
//   actual_brch_result      : resolved outcome (1 = taken)
//   brch_target_ID          : resolved taken target
//   flush_IF_ID             : squash the IF instruction (combinational)
//   redirect_valid          : load redirect_pc at next edge (combinational)
//   redirect_pc             : corrected fetch address, 0 when not redirecting
//   branch_cnt              : resolved branches, saturating
//   mispredict_cnt          : mispredicted branches, saturating
module brnch_resolve_unit
  import brnch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_IF_ID,
  input  logic              brch_instr_detectd_IF,
  input  logic              predict_br_taken,
  input  logic [ADDR_W-1:0] pc_plus4_IF,
  input  logic              brch_instr_detectd_ID,
  input  logic              actual_brch_result,
  input  logic [ADDR_W-1:0] brch_target_ID,
  output logic              flush_IF_ID,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  brr_state_t        state;
  logic              pred_vld_ID;
  logic              pred_taken_ID;
  logic [ADDR_W-1:0] pc_plus4_ID;

  logic resolve;
  logic eff_pred;
  logic mispredict;

  // A branch with no valid shadow entry is treated as predicted not-taken.
  assign eff_pred   = pred_taken_ID & pred_vld_ID;
  assign resolve    = brch_instr_detectd_ID & ~stall_IF_ID & (state == NORMAL);
  assign mispredict = resolve & (eff_pred != actual_brch_result);

  always_comb begin
    flush_IF_ID    = mispredict;
    redirect_valid = mispredict;
    redirect_pc    = '0;
    if (mispredict) begin
      redirect_pc = actual_brch_result ? brch_target_ID : pc_plus4_ID;
    end
  end

  // Shadow of the prediction travelling with the branch from IF into ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_vld_ID   <= 1'b0;
      pred_taken_ID <= 1'b0;
      pc_plus4_ID   <= '0;
    end else if (!stall_IF_ID) begin
      if (flush_IF_ID) begin
        pred_vld_ID   <= 1'b0;
        pred_taken_ID <= 1'b0;
      end else begin
        pred_vld_ID   <= brch_instr_detectd_IF;
        pred_taken_ID <= predict_br_taken & brch_instr_detectd_IF;
        pc_plus4_ID   <= pc_plus4_IF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
    end else begin
      case (state)
        NORMAL:  state <= mispredict ? RECOVER : NORMAL;
        RECOVER: state <= NORMAL;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (resolve),
    .cnt (branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mispredict_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mispredict),
    .cnt (mispredict_cnt)
  );

endmodule

// File: doc/brnch_resolve_unit.md
# brnch_resolve_unit

Branch resolution and misprediction recovery unit for the 5-stage MIPS pipeline. It is the consumer of the dynamic predictor's IF-stage `predict_br_taken`. It carries each prediction alongside its branch from IF into ID and compares it against the actual outcome resolved in ID. On a mismatch it flushes IF/ID and redirects the PC. It also keeps saturating branch and misprediction counters for performance monitoring.

## Interface
Parameters:
- `ADDR_W`, default 32: PC/address width.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_IF_ID`  in  1  hazard stall; IF/ID holds and no resolution occurs.
- `brch_instr_detectd_IF`  in  1  a branch is in IF this cycle.
- `predict_br_taken`  in  1  predictor output for the IF branch.
- `pc_plus4_IF`  in  ADDR_W  PC+4 of the IF instruction.
- `brch_instr_detectd_ID`  in  1  a branch is in ID and resolved this cycle.
- `actual_brch_result`  in  1  resolved outcome, 1 = taken.
- `brch_target_ID`  in  ADDR_W  resolved taken target.
- `flush_IF_ID`  out  1  squash the instruction currently in IF.
- `redirect_valid`  out  1  PC must load `redirect_pc` at the next edge.
- `redirect_pc`  out  ADDR_W  corrected fetch address.
- `branch_cnt`  out  CNT_W  resolved branches, saturating.
- `mispredict_cnt`  out  CNT_W  mispredicted branches, saturating.

## Operation
- Shadow register (`pred_vld_ID`, `pred_taken_ID`, `pc_plus4_ID`):
  - When `!stall_IF_ID && !flush_IF_ID`, it loads `brch_instr_detectd_IF`, `predict_br_taken & brch_instr_detectd_IF`, and `pc_plus4_IF`.
  - On stall it holds.
  - On flush it clears `pred_vld_ID` and `pred_taken_ID`.
- `resolve = brch_instr_detectd_ID & !stall_IF_ID & (state == NORMAL)`.
- The effective prediction is `pred_taken_ID & pred_vld_ID`. A branch without a valid shadow entry counts as predicted not-taken.
- `mispredict = resolve & (effective prediction != actual_brch_result)`.
- On `mispredict`:
  - `flush_IF_ID` = 1 and `redirect_valid` = 1.
  - `redirect_pc` = `brch_target_ID` when actually taken, otherwise `pc_plus4_ID`.
  - When `redirect_valid` = 0, `redirect_pc` is driven to 0.
- FSM states:
  - NORMAL: on `mispredict`, go to RECOVER; otherwise stay.
  - RECOVER: one cycle. `brch_instr_detectd_ID` is ignored (the ID slot holds the squashed instruction) and no outputs assert. Return to NORMAL unconditionally.
- Counters:
  - `branch_cnt` increments on `resolve`.
  - `mispredict_cnt` increments on `mispredict`.
  - Both saturate at 2^CNT_W−1; no wrap.
- Training the predictor is outside this unit. The predictor samples `brch_instr_detectd_ID` and `actual_brch_result` directly.

## Timing
- `flush_IF_ID`, `redirect_valid`, and `redirect_pc` are combinational from the shadow register and ID inputs: zero-cycle latency, asserted in the resolving cycle.
- A prediction made in IF in cycle N is compared in the first non-stalled cycle at or after N+1.
- Counters and the FSM update at the edge that ends the resolving cycle.
- Reset:
  - `rst` overrides everything: FSM = NORMAL, shadow cleared, counters = 0.
  - All outputs read 0 in the cycle after `rst` is sampled. Combinational outputs also read 0 while state is reset, because `pred_vld_ID` = 0 and resolution requires a detect.
- Reset during RECOVER returns to NORMAL with no pending flush.
- A branch held in ID across stall cycles resolves exactly once, in its non-stalled cycle.
- A correct prediction produces no flush, stays in NORMAL, and increments `branch_cnt` only.
- Back-to-back branches, with no mispredict, each resolve in consecutive cycles.

## Structure
- Package `brnch_pkg` holds:
  - `typedef enum logic {NORMAL, RECOVER} brr_state_t`
  - `localparam` defaults for `ADDR_W` and `CNT_W`
- Sub-module `sat_counter`, parameterized by width with inputs `clk`, `rst`, and `inc`, output `cnt`. It is instantiated twice, for `branch_cnt` and `mispredict_cnt`.

## Test plan
- Reset with all inputs at 0, then release. All outputs stay 0 for 5 cycles.
- Predict taken at `pc_plus4_IF` = 0x104, then ID resolves not-taken. `flush_IF_ID` = `redirect_valid` = 1 with `redirect_pc` = 0x104 in the resolving cycle. Next cycle is RECOVER. `mispredict_cnt` = 1 and `branch_cnt` = 1.
- Predict not-taken, then ID resolves taken with `brch_target_ID` = 0x2000. Redirect to 0x2000 with one flush pulse.
- Hold `stall_IF_ID` = 1 for 3 cycles with a mispredicting branch in ID. No flush during the stall; a single flush in the release cycle; the counters increment once.
- Assert a detect in the RECOVER cycle. It is ignored, with no redirect and no count. Force `CNT_W` = 2 with 5 mispredicts: `mispredict_cnt` = 3.
- Assert `rst` in the RECOVER cycle. Next cycle is NORMAL with counters 0, and a correct prediction afterward produces no flush.
